// File: rtl/add_serial_ctrl.sv
// add_serial_ctrl: operand FIFO + scheduler + result collector in front of add_serial.
// Latency: push at edge P into an idle block -> add_en during P+1..P+2, res_valid at P+2+ADD_LAT.
// Backpressure: in_ready = !full; a held result (res_valid && !res_ready) blocks further issues.
// Optional statistics (op_count, ovf) are built only when ADD_SERIAL_CTRL_STATS_EN is defined.
module add_serial_ctrl #(
  parameter int DEPTH   = 4,
  parameter int ADD_LAT = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  output logic       add_en,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  input  logic [7:0] add_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       busy
`ifdef ADD_SERIAL_CTRL_STATS_EN
  ,
  output logic [15:0] op_count,
  output logic        ovf
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(ADD_LAT + 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [LW-1:0] LAT_LOAD = LW'(ADD_LAT);
  localparam logic [LW-1:0] LAT_LAST = LW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]    state;
  logic [LW-1:0] wait_cnt;
  logic [7:0]    mem_a [DEPTH];
  logic [7:0]    mem_b [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  logic          start;
  logic          capture;
  logic          handshake;

  // in_ready depends on occupancy alone, so no input can reach it combinationally.
  assign in_ready  = (count != FULL_CNT);
  assign push      = in_valid && in_ready;
  assign pop       = (state == S_ISSUE);
  assign start     = (state == S_IDLE) && (count != '0) && !res_valid;
  assign capture   = (state == S_WAIT) && (wait_cnt == LAT_LAST);
  assign handshake = (state == S_HOLD) && res_ready;
  assign add_en    = (state == S_ISSUE);
  assign busy      = (state != S_IDLE) || (count != '0);

  // Operand storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sequencer: issue one pair, wait the adder latency, hold the result until taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= S_ISSUE;
        end
        S_ISSUE: begin
          wait_cnt <= LAT_LOAD;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (capture) state <= S_HOLD;
        end
        default: begin
          if (res_ready) state <= S_IDLE;
        end
      endcase
    end
  end

  // Adder operands are latched only when entering ISSUE, so later pushes cannot disturb them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      add_a <= '0;
      add_b <= '0;
    end else if (start) begin
      add_a <= mem_a[rd_ptr];
      add_b <= mem_b[rd_ptr];
    end
  end

  // Result register: res_data keeps its value after the handshake until the next capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      if (capture) begin
        res_valid <= 1'b1;
        res_data  <= add_out;
      end else if (handshake) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef ADD_SERIAL_CTRL_STATS_EN
  logic [8:0] sum_wide;
  assign sum_wide = {1'b0, add_a} + {1'b0, add_b};

  // Handshake counter (wraps naturally) and carry-out captured with each result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_count <= '0;
      ovf      <= 1'b0;
    end else begin
      if (handshake) op_count <= op_count + 16'd1;
      if (capture)   ovf      <= sum_wide[8];
    end
  end
`endif

endmodule

// File: tb/tb_add_serial_ctrl.sv
// Bench for add_serial_ctrl with a behavioural add_serial model and a result scoreboard.
// Stimulus is driven on the falling edge; the monitor samples 2ns after the falling edge.
// Expected sums are computed from the pushed operands and queued in issue order.
module tb_add_serial_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic       add_en;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic [7:0] add_out;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic       busy;
`ifdef ADD_SERIAL_CTRL_STATS_EN
  logic [15:0] op_count;
  logic        ovf;
`endif

  add_serial_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .add_en    (add_en),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_out   (add_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy)
`ifdef ADD_SERIAL_CTRL_STATS_EN
    ,
    .op_count  (op_count),
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural serial adder: loads on an edge with en high, garbage output until
  // 8 edges later, so the controller's capture one edge after that sees the sum.
  logic [7:0] m_pend = 8'h00;
  logic [7:0] m_out  = 8'h00;
  int         m_cnt  = 0;
  assign add_out = m_out;
  always @(posedge clk) begin
    if (add_en) begin
      m_pend <= 8'(add_a + add_b);
      m_out  <= 8'hEE;
      m_cnt  <= 8;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_out <= m_pend;
    end
  end

  int tests = 0;
  int fails = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  int hs_edge = 0;
  int hs_cnt = 0;
  int en_cnt = 0;
  int issue_edge = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every result handshake and counts issue pulses.
  always @(negedge clk) begin
    #2;
    if (rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got 0x%0h, expected no result", res_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("res_data", int'(res_data), int'(mon_e[7:0]));
`ifdef ADD_SERIAL_CTRL_STATS_EN
        chk("ovf", int'(ovf), int'(mon_e[8]));
`endif
      end
      hs_edge = cyc + 1;
      hs_cnt++;
    end
    if (rst && add_en) begin
      en_cnt++;
      issue_edge = cyc;
    end
  end

  task automatic push_op(input logic [7:0] a, input logic [7:0] b, output int acc);
    int n;
    n = 0;
    acc = -1;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL push_accept: in_ready stayed 0, required 1");
    end else begin
      @(posedge clk);
      #1;
      acc = cyc;
      exp_q.push_back({1'b0, a} + {1'b0, b});
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  function automatic logic cond(input int w);
    case (w)
      0:       return res_valid;
      1:       return !res_valid;
      2:       return add_en;
      default: return !busy;
    endcase
  endfunction

  task automatic wait_for(input int w, input string nm);
    int n;
    n = 0;
    while (!cond(w) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!cond(w)) begin
      tests++;
      fails++;
      $display("FAIL %s: condition not reached within 400 cycles, required reached", nm);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  int'(in_ready),  1);
    chk({tag, "_add_en"},    int'(add_en),    0);
    chk({tag, "_add_a"},     int'(add_a),     0);
    chk({tag, "_add_b"},     int'(add_b),     0);
    chk({tag, "_res_valid"}, int'(res_valid), 0);
    chk({tag, "_res_data"},  int'(res_data),  0);
    chk({tag, "_busy"},      int'(busy),      0);
`ifdef ADD_SERIAL_CTRL_STATS_EN
    chk({tag, "_op_count"},  int'(op_count),  0);
    chk({tag, "_ovf"},       int'(ovf),       0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int p;
    int h;
    int acc5;
    int dummy;
    int en_before;
    int base_hs;
    logic [7:0] pa [4];
    logic [7:0] pb [4];
    pa[0] = 8'h11; pb[0] = 8'h22;
    pa[1] = 8'h80; pb[1] = 8'h80;
    pa[2] = 8'h0F; pb[2] = 8'hF1;
    pa[3] = 8'h55; pb[3] = 8'h2A;
    base_hs = 0;

    // Reset values
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b1;
    @(negedge clk);

    // Single op with latency check
    en_before = en_cnt;
    push_op(8'h3C, 8'h15, p);
    @(negedge clk);
    chk("issue_add_en", int'(add_en), 1);
    chk("issue_add_a", int'(add_a), 8'h3C);
    chk("issue_add_b", int'(add_b), 8'h15);
    @(negedge clk);
    chk("wait_add_en_low", int'(add_en), 0);
    wait_for(0, "single_res_valid");
    chk("res_valid_edge", cyc, p + 11);
    chk("single_en_pulses", en_cnt - en_before, 1);
    res_ready = 1'b1;
    wait_for(1, "single_handshake");
    chk("res_data_held", int'(res_data), 8'h51);

    // Wrap sum
    push_op(8'hFF, 8'h01, p);
    wait_for(0, "wrap_res_valid");
    wait_for(1, "wrap_handshake");

    // Backpressure with FIFO filling behind a pending result
    res_ready = 1'b0;
    push_op(8'hA0, 8'h05, p);
    wait_for(0, "bp_res_valid");
    h = 0;
    acc5 = -1;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          chk("bp_res_valid_held", int'(res_valid), 1);
          chk("bp_res_data_stable", int'(res_data), 8'hA5);
          chk("bp_no_add_en", int'(add_en), 0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        h = cyc;
      end
      begin
        for (int i = 0; i < 4; i++) push_op(pa[i], pb[i], dummy);
        chk("full_in_ready", int'(in_ready), 0);
        push_op(8'hC8, 8'h64, acc5);
      end
    join
    chk("fifth_accept_edge", acc5, h + 3);
    chk("issue_after_release", issue_edge, h + 1);
    wait_for(3, "bp_drain");

    // Reset in the middle of WAIT
    push_op(8'h40, 8'h40, p);
    wait_for(2, "rst_issue");
    repeat (4) @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk_reset_vals("midrst");
    exp_q.delete();
    base_hs = hs_cnt;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push_op(8'h10, 8'h20, p);
    wait_for(0, "post_rst_res_valid");
    wait_for(1, "post_rst_handshake");

    // Ordering
    push_op(8'h01, 8'h02, p);
    push_op(8'h10, 8'h20, p);
    push_op(8'h7F, 8'h01, p);
    wait_for(3, "order_drain");
    chk("busy_fall_edge", cyc, hs_edge);
    chk("order_res_valid", int'(res_valid), 0);
    @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
`ifdef ADD_SERIAL_CTRL_STATS_EN
    chk("op_count", int'(op_count), hs_cnt - base_hs);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
